// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants for the UART transmit feeder: FSM encoding,
//               byte width and bytes-per-word helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    localparam int BYTE_WIDTH = 8;

    // One-hot feeder FSM encoding
    localparam logic [3:0] c_ST_IDLE = 4'b0001;
    localparam logic [3:0] c_ST_LOAD = 4'b0010;
    localparam logic [3:0] c_ST_SEND = 4'b0100;
    localparam logic [3:0] c_ST_GAP  = 4'b1000;

    function automatic int nbytes(input int word_width);
        return word_width / BYTE_WIDTH;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock word FIFO with registered flags, occupancy count,
//               registered read data and a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK100MHZ,
    input  logic                  RESET,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow
);

    localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   w_count_nxt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_overflow;
    logic [WIDTH-1:0]      r_rd_data;
    logic                  w_push;
    logic                  w_pop;

    // A write while full is dropped even if a pop frees a slot this cycle
    assign w_push = i_wr_en & ~r_full;
    assign w_pop  = i_rd_en & ~r_empty;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - 1'b1;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr];
            end
            if (i_wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == c_DEPTH);
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_full     = r_full;
    assign o_empty    = r_empty;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/uart_tx_word_feeder.sv
// ============================================================================
// Module      : uart_tx_word_feeder
// Description : Buffers result words and feeds them LSB byte first to the UART
//               transmitter over its TXEN-level / DONE-pulse handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_word_feeder
    import uart_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK100MHZ,
    input  logic                  RESET,
    input  logic                  WR_EN,
    input  logic [WORD_WIDTH-1:0] WR_DATA,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT,
    output logic                  OVERFLOW,
    output logic                  BUSY,
    output logic                  TXEN,
    output logic [7:0]            TX_DATA,
    input  logic                  TX_DONE
);

    localparam int c_NBYTES = nbytes(WORD_WIDTH);
    localparam int c_BIDX_W = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;
    localparam logic [c_BIDX_W-1:0] c_LAST_BIDX = c_BIDX_W'(c_NBYTES - 1);

    logic [3:0]            r_state;
    logic [3:0]            w_state_nxt;
    logic [WORD_WIDTH-1:0] r_sr;
    logic [c_BIDX_W-1:0]   r_bidx;
    logic                  r_txen;
    logic [7:0]            r_tx_data;

    logic                  w_pop;
    logic                  w_sr_load;
    logic                  w_send_done;
    logic                  w_next_byte;
    logic                  w_last_byte;

    logic [WORD_WIDTH-1:0] w_fifo_rdata;
    logic                  w_fifo_empty;

    sync_fifo #(
        .WIDTH      (WORD_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
        .CLK100MHZ  (CLK100MHZ),
        .RESET      (RESET),
        .i_wr_en    (WR_EN),
        .i_wr_data  (WR_DATA),
        .i_rd_en    (w_pop),
        .o_rd_data  (w_fifo_rdata),
        .o_full     (FULL),
        .o_empty    (w_fifo_empty),
        .o_count    (COUNT),
        .o_overflow (OVERFLOW)
    );

    assign w_last_byte = (r_bidx == c_LAST_BIDX);

    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (!w_fifo_empty) w_state_nxt = c_ST_LOAD;
            c_ST_LOAD: w_state_nxt = c_ST_SEND;
            c_ST_SEND: if (TX_DONE) w_state_nxt = c_ST_GAP;
            c_ST_GAP: begin
                if (!w_last_byte) begin
                    w_state_nxt = c_ST_SEND;
                end else if (!w_fifo_empty) begin
                    w_state_nxt = c_ST_LOAD;
                end else begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    // TX_DONE only matters in SEND; everywhere else it is ignored
    always_comb begin
        w_pop       = 1'b0;
        w_sr_load   = 1'b0;
        w_send_done = 1'b0;
        w_next_byte = 1'b0;
        case (r_state)
            c_ST_IDLE: w_pop       = ~w_fifo_empty;
            c_ST_LOAD: w_sr_load   = 1'b1;
            c_ST_SEND: w_send_done = TX_DONE;
            c_ST_GAP: begin
                w_next_byte = ~w_last_byte;
                w_pop       = w_last_byte & ~w_fifo_empty;
            end
            default: ;
        endcase
    end

    // TXEN and TX_DATA are registered on the edge entering SEND so the byte is stable for the frame
    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            r_sr      <= '0;
            r_bidx    <= '0;
            r_txen    <= 1'b0;
            r_tx_data <= '0;
        end else if (w_sr_load) begin
            r_sr      <= w_fifo_rdata;
            r_bidx    <= '0;
            r_txen    <= 1'b1;
            r_tx_data <= w_fifo_rdata[7:0];
        end else if (w_send_done) begin
            r_sr      <= r_sr >> BYTE_WIDTH;
            r_txen    <= 1'b0;
        end else if (w_next_byte) begin
            r_bidx    <= r_bidx + 1'b1;
            r_txen    <= 1'b1;
            r_tx_data <= r_sr[7:0];
        end
    end

    assign EMPTY   = w_fifo_empty;
    assign BUSY    = (r_state != c_ST_IDLE);
    assign TXEN    = r_txen;
    assign TX_DATA = r_tx_data;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_word_feeder.sv
// ============================================================================
// Module      : tb_uart_tx_word_feeder
// Description : Directed bench for uart_tx_word_feeder with a behavioural
//               transmitter handshake model and a byte scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_word_feeder;

    localparam int BYTE_CYC = 12;
    localparam int WAIT_MAX = 2000;

    logic        CLK100MHZ = 1'b0;
    logic        RESET     = 1'b0;
    logic        WR_EN     = 1'b0;
    logic [31:0] WR_DATA   = '0;
    logic        FULL;
    logic        EMPTY;
    logic [4:0]  COUNT;
    logic        OVERFLOW;
    logic        BUSY;
    logic        TXEN;
    logic [7:0]  TX_DATA;
    logic        TX_DONE   = 1'b0;

    uart_tx_word_feeder #(
        .WORD_WIDTH (32),
        .FIFO_DEPTH (16),
        .ADDR_WIDTH (4)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .RESET     (RESET),
        .WR_EN     (WR_EN),
        .WR_DATA   (WR_DATA),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .COUNT     (COUNT),
        .OVERFLOW  (OVERFLOW),
        .BUSY      (BUSY),
        .TXEN      (TXEN),
        .TX_DATA   (TX_DATA),
        .TX_DONE   (TX_DONE)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    typedef struct {
        logic [7:0] data;
        int         gap;   // expected TXEN-low cycles before this byte, -1 = not checked
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    int done_total = 0;
    int rise_total = 0;
    int done_grant = 0;
    bit free_run   = 1'b0;
    int spur_req   = 0;
    int spur_ack   = 0;
    int hi_cnt     = 0;
    int low_cnt    = 0;
    logic prev_txen = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Transmitter model: DONE after BYTE_CYC cycles of TXEN, gated by grant
    always @(negedge CLK100MHZ) begin
        if (RESET) begin
            TX_DONE   = 1'b0;
            hi_cnt    = 0;
            low_cnt   = 0;
            prev_txen = 1'b0;
        end else begin
            if (TXEN && !prev_txen) begin
                rise_total++;
                chk("sb_has_byte_at_txen", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0 && sb[0].gap >= 0) begin
                    chk("txen_low_gap", 32'(low_cnt), 32'(sb[0].gap));
                end
                low_cnt = 0;
                hi_cnt  = 0;
            end
            prev_txen = TXEN;
            if (TX_DONE) begin
                if (spur_req != spur_ack) spur_ack++;
                else TX_DONE = 1'b0;
            end else if (spur_req != spur_ack) begin
                TX_DONE = 1'b1;
                spur_ack++;
            end else if (TXEN) begin
                hi_cnt++;
                if (hi_cnt >= BYTE_CYC && (free_run || done_total < done_grant)) begin
                    chk("sb_has_byte_at_done", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("tx_byte", 32'(TX_DATA), 32'(e.data));
                    end
                    TX_DONE = 1'b1;
                    done_total++;
                end
            end
            if (!TXEN) low_cnt++;
        end
    end

    task automatic write_word(input logic [31:0] w, input bit accept, input bit first);
        WR_EN   = 1'b1;
        WR_DATA = w;
        if (accept) begin
            for (int i = 0; i < 4; i++) begin
                exp_t e;
                e.data = w[8*i +: 8];
                e.gap  = (i != 0) ? 1 : (first ? -1 : 2);
                sb.push_back(e);
            end
        end
        @(posedge CLK100MHZ); #1;
        WR_EN = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (n < WAIT_MAX && !(sb.size() == 0 && !BUSY && EMPTY)) begin
            @(posedge CLK100MHZ); #1;
            n++;
        end
        chk(tag, 32'(n < WAIT_MAX), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int target);
        int n = 0;
        while (n < WAIT_MAX && done_total < target) begin
            @(posedge CLK100MHZ); #1;
            n++;
        end
        chk(tag, 32'(n < WAIT_MAX), 32'd1);
    endtask

    task automatic apply_reset();
        RESET      = 1'b1;
        sb.delete();
        free_run   = 1'b0;
        done_grant = done_total;
        repeat (2) @(posedge CLK100MHZ);
        #1;
        RESET = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int rbase;

        // Reset values
        #1;
        RESET = 1'b1;
        repeat (2) @(posedge CLK100MHZ);
        #1;
        chk("rst_txen",     32'(TXEN),     32'd0);
        chk("rst_tx_data",  32'(TX_DATA),  32'd0);
        chk("rst_busy",     32'(BUSY),     32'd0);
        chk("rst_full",     32'(FULL),     32'd0);
        chk("rst_empty",    32'(EMPTY),    32'd1);
        chk("rst_count",    32'(COUNT),    32'd0);
        chk("rst_overflow", 32'(OVERFLOW), 32'd0);
        RESET = 1'b0;
        @(posedge CLK100MHZ); #1;

        // 1: single word, latency and byte order
        free_run = 1'b1;
        base  = done_total;
        rbase = rise_total;
        write_word(32'hA1B2C3D4, 1'b1, 1'b1);
        chk("t1_empty_after_write", 32'(EMPTY), 32'd0);
        chk("t1_txen_edge_n",       32'(TXEN),  32'd0);
        @(posedge CLK100MHZ); #1;
        chk("t1_busy_after_pop",    32'(BUSY),  32'd1);
        chk("t1_empty_after_pop",   32'(EMPTY), 32'd1);
        chk("t1_txen_in_load",      32'(TXEN),  32'd0);
        @(posedge CLK100MHZ); #1;
        chk("t1_txen_first_byte",   32'(TXEN),    32'd1);
        chk("t1_first_byte",        32'(TX_DATA), 32'hD4);
        wait_idle("t1_idle_timeout");
        chk("t1_done_pulses", 32'(done_total - base), 32'd4);
        chk("t1_txen_pulses", 32'(rise_total - rbase), 32'd4);
        chk("t1_end_busy",    32'(BUSY),  32'd0);
        chk("t1_end_empty",   32'(EMPTY), 32'd1);

        // 2: three words back-to-back
        base = done_total;
        write_word(32'h11223344, 1'b1, 1'b1);
        write_word(32'h55667788, 1'b1, 1'b0);
        write_word(32'h99AABBCC, 1'b1, 1'b0);
        wait_idle("t2_idle_timeout");
        chk("t2_done_pulses", 32'(done_total - base), 32'd12);

        // 6: spurious TX_DONE in IDLE and in GAP
        spur_req++;
        repeat (3) @(posedge CLK100MHZ);
        #1;
        chk("t6_idle_busy",  32'(BUSY),  32'd0);
        chk("t6_idle_empty", 32'(EMPTY), 32'd1);
        chk("t6_idle_count", 32'(COUNT), 32'd0);
        chk("t6_idle_txen",  32'(TXEN),  32'd0);
        free_run   = 1'b0;
        done_grant = done_total + 1;
        write_word(32'h0F1E2D3C, 1'b1, 1'b1);
        wait_done("t6_byte0_timeout", done_grant);
        spur_req++;
        @(posedge CLK100MHZ); #1;
        chk("t6_gap_txen",    32'(TXEN),    32'd1);
        chk("t6_gap_data",    32'(TX_DATA), 32'h2D);
        @(posedge CLK100MHZ); #1;
        chk("t6_hold_txen",   32'(TXEN),    32'd1);
        chk("t6_hold_data",   32'(TX_DATA), 32'h2D);
        free_run = 1'b1;
        wait_idle("t6_idle_timeout");

        // 3: fill with the transmitter stalled, then overflow
        apply_reset();
        for (int i = 1; i <= 17; i++) begin
            write_word(32'h44332211 + 32'(i) * 32'h01010101, 1'b1, i == 1);
        end
        chk("t3_count_full",   32'(COUNT),    32'd16);
        chk("t3_full",         32'(FULL),     32'd1);
        chk("t3_no_overflow",  32'(OVERFLOW), 32'd0);
        write_word(32'hDEADBEEF, 1'b0, 1'b0);
        chk("t3_overflow",     32'(OVERFLOW), 32'd1);
        chk("t3_count_after",  32'(COUNT),    32'd16);

        // 4: write while full on the GAP-to-LOAD pop edge
        apply_reset();
        chk("t4_overflow_cleared", 32'(OVERFLOW), 32'd0);
        for (int i = 1; i <= 17; i++) begin
            write_word(32'h44332211 + 32'(i) * 32'h01010101, 1'b1, i == 1);
        end
        chk("t4_full", 32'(FULL), 32'd1);
        done_grant = done_total + 4;
        wait_done("t4_word_timeout", done_grant);
        WR_EN   = 1'b1;
        WR_DATA = 32'hBADC0FFE;
        @(posedge CLK100MHZ); #1;
        WR_EN = 1'b0;
        chk("t4_count_after_pop", 32'(COUNT),    32'd15);
        chk("t4_overflow",        32'(OVERFLOW), 32'd1);
        chk("t4_not_full",        32'(FULL),     32'd0);

        // 5: reset in the middle of the second byte
        done_grant = done_total + 1;
        wait_done("t5_byte0_timeout", done_grant);
        repeat (4) @(posedge CLK100MHZ);
        #1;
        chk("t5_mid_txen", 32'(TXEN),    32'd1);
        chk("t5_mid_data", 32'(TX_DATA), 32'h24);
        #2;
        RESET = 1'b1;
        sb.delete();
        #1;
        chk("t5_async_txen",     32'(TXEN),     32'd0);
        chk("t5_async_tx_data",  32'(TX_DATA),  32'd0);
        chk("t5_async_busy",     32'(BUSY),     32'd0);
        chk("t5_async_count",    32'(COUNT),    32'd0);
        chk("t5_async_empty",    32'(EMPTY),    32'd1);
        chk("t5_async_overflow", 32'(OVERFLOW), 32'd0);
        repeat (2) @(posedge CLK100MHZ);
        #1;
        RESET = 1'b0;
        @(posedge CLK100MHZ); #1;
        chk("t5_after_busy", 32'(BUSY), 32'd0);
        chk("t5_after_full", 32'(FULL), 32'd0);
        free_run = 1'b1;
        base = done_total;
        write_word(32'h55667788, 1'b1, 1'b1);
        wait_idle("t5_idle_timeout");
        chk("t5_done_pulses", 32'(done_total - base), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
